// File: rtl/dac_spi_serializer.sv
// Sample FIFO plus SPI mode-0 serializer for an MCP4921-class DAC (16-bit frames: 4 config + 12 data bits).
// Define DAC_SIGNED_OFFSET_EN to treat sample_in as two's-complement and convert it to offset binary.
module dac_spi_serializer #(
  parameter int         CLK_DIV    = 4,
  parameter logic [3:0] CFG_BITS   = 4'b0011,
  parameter int         FIFO_DEPTH = 4,
  parameter int         GAP_CYCLES = 2
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        spi_audio_clk,
  output logic        spi_mosi_out,
  output logic        spi_active_out,
  output logic        busy,
  output logic [7:0]  overflow_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t        state;
  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [14:0]   shift_reg;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  logic [3:0]    bit_cnt;
  logic          half;

  logic [11:0] dac12;
  logic        unused_low;
  logic        full;
  logic        gap_done;
  logic        launch;
  logic        push;
  logic        drop;
  logic        frame_next;

  // The FIFO holds the already-converted 12-bit code; the low nibble is discarded.
`ifdef DAC_SIGNED_OFFSET_EN
  assign dac12 = {~sample_in[15], sample_in[14:4]};
`else
  assign dac12 = sample_in[15:4];
`endif
  assign unused_low = ^sample_in[3:0];

  assign full     = (count == CW'(FIFO_DEPTH));
  assign gap_done = (gap_cnt == GW'(GAP_CYCLES - 1));
  // Launching a frame pops the FIFO; a full FIFO can accept a write on that same edge.
  assign launch   = (count != '0) && ((state == IDLE) || ((state == GAP) && gap_done));
  assign push     = sample_valid && (!full || launch);
  assign drop     = sample_valid && !push;
  assign frame_next = launch || (state == LOAD) || (state == SHIFT) ||
                      ((state == GAP) && !gap_done);

  always_comb begin
    count_next = count;
    if (push && !launch) count_next = count + CW'(1);
    else if (!push && launch) count_next = count - CW'(1);
  end

  always_ff @(posedge clk_25mhz) begin
    if (push) mem[wr_ptr] <= dac12;
  end

  always_ff @(posedge clk_25mhz) begin
    if (!reset) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      shift_reg      <= '0;
      div_cnt        <= '0;
      gap_cnt        <= '0;
      bit_cnt        <= '0;
      half           <= 1'b0;
      sample_ready   <= 1'b1;
      spi_audio_clk  <= 1'b0;
      spi_mosi_out   <= 1'b0;
      spi_active_out <= 1'b0;
      busy           <= 1'b0;
      overflow_count <= '0;
    end else begin
      count        <= count_next;
      sample_ready <= (count_next != CW'(FIFO_DEPTH));
      busy         <= frame_next || (count_next != '0);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (launch) rd_ptr <= rd_ptr + AW'(1);
      if (drop && (overflow_count != 8'hFF)) overflow_count <= overflow_count + 8'd1;

      if (launch) begin
        shift_reg      <= {CFG_BITS[2:0], mem[rd_ptr]};
        spi_mosi_out   <= CFG_BITS[3];
        spi_active_out <= 1'b1;
        spi_audio_clk  <= 1'b0;
        state          <= LOAD;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            div_cnt <= '0;
            half    <= 1'b0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
          // Each bit is CLK_DIV cycles low then CLK_DIV cycles high; MOSI advances on the fall.
          SHIFT: begin
            if (div_cnt == DW'(CLK_DIV - 1)) begin
              div_cnt <= '0;
              if (!half) begin
                spi_audio_clk <= 1'b1;
                half          <= 1'b1;
              end else begin
                spi_audio_clk <= 1'b0;
                half          <= 1'b0;
                if (bit_cnt == 4'd15) begin
                  spi_active_out <= 1'b0;
                  spi_mosi_out   <= 1'b0;
                  gap_cnt        <= '0;
                  state          <= GAP;
                end else begin
                  bit_cnt      <= bit_cnt + 4'd1;
                  spi_mosi_out <= shift_reg[14];
                  shift_reg    <= {shift_reg[13:0], 1'b0};
                end
              end
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
          end
          GAP: begin
            if (gap_done) state <= IDLE;
            else gap_cnt <= gap_cnt + GW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Directed bench for dac_spi_serializer: frame contents, timing, overflow, gap and mid-frame reset.
// Expected frame values follow DAC_SIGNED_OFFSET_EN in the same way as the design.
module tb_dac_spi_serializer;

  logic        clk_25mhz = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        spi_audio_clk;
  logic        spi_mosi_out;
  logic        spi_active_out;
  logic        busy;
  logic [7:0]  overflow_count;

  dac_spi_serializer dut (
    .clk_25mhz      (clk_25mhz),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .spi_audio_clk  (spi_audio_clk),
    .spi_mosi_out   (spi_mosi_out),
    .spi_active_out (spi_active_out),
    .busy           (busy),
    .overflow_count (overflow_count)
  );

  always #5 clk_25mhz = ~clk_25mhz;

  typedef struct {
    logic [15:0] sample;
    logic [15:0] frame;
  } vec_t;

  int total = 0;
  int bad = 0;

  logic [15:0] cap = '0;
  int          rises = 0;
  int          act_len = 0;
  int          gap_len = 0;
  bit          in_gap = 1'b0;
  logic        prev_act = 1'b0;
  logic [15:0] frames[$];
  int          lens[$];
  int          frame_rises[$];
  int          gaps[$];

  // The DAC samples MOSI on each SCLK rise.
  always @(posedge spi_audio_clk) begin
    cap = {cap[14:0], spi_mosi_out};
    rises++;
  end

  always @(negedge clk_25mhz) begin
    if (spi_active_out) begin
      if (!prev_act) begin
        if (in_gap) begin
          gaps.push_back(gap_len);
          in_gap = 1'b0;
        end
        act_len = 1;
        rises = 0;
        cap = '0;
      end else begin
        act_len++;
      end
    end else begin
      if (prev_act) begin
        frames.push_back(cap);
        lens.push_back(act_len);
        frame_rises.push_back(rises);
        in_gap = 1'b1;
        gap_len = 0;
      end
      if (in_gap) gap_len++;
    end
    prev_act = spi_active_out;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] s);
    @(negedge clk_25mhz);
    sample_in = s;
    sample_valid = 1'b1;
    @(negedge clk_25mhz);
    sample_valid = 1'b0;
  endtask

  task automatic clearMon();
    frames.delete();
    lens.delete();
    frame_rises.delete();
    gaps.delete();
    in_gap = 1'b0;
    rises = 0;
  endtask

  task automatic doReset();
    @(negedge clk_25mhz);
    reset = 1'b0;
    sample_valid = 1'b0;
    repeat (5) @(negedge clk_25mhz);
    reset = 1'b1;
    clearMon();
  endtask

  task automatic waitFrames(input int n, input int budget);
    int c = 0;
    while (frames.size() < n && c < budget) begin
      @(negedge clk_25mhz);
      c++;
    end
    checkOutput("frames_seen", frames.size(), n);
  endtask

  task automatic watchIdle(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(negedge clk_25mhz);
      if (spi_active_out) seen++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   seen;
    int   c;

`ifdef DAC_SIGNED_OFFSET_EN
    vecs[0] = '{16'hC0DE, 16'h340D};
    vecs[1] = '{16'h0000, 16'h3800};
    vecs[2] = '{16'hFFFF, 16'h37FF};
    vecs[3] = '{16'h8000, 16'h3000};
    vecs[4] = '{16'h7FFF, 16'h3FFF};
    vecs[5] = '{16'h123F, 16'h3923};
`else
    vecs[0] = '{16'hC0DE, 16'h3C0D};
    vecs[1] = '{16'h0000, 16'h3000};
    vecs[2] = '{16'hFFFF, 16'h3FFF};
    vecs[3] = '{16'h8000, 16'h3800};
    vecs[4] = '{16'h7FFF, 16'h37FF};
    vecs[5] = '{16'h123F, 16'h3123};
`endif

    $display("[TB] reset and idle");
    doReset();
    checkOutput("rst_sclk", spi_audio_clk, 0);
    checkOutput("rst_mosi", spi_mosi_out, 0);
    checkOutput("rst_active", spi_active_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overflow", overflow_count, 0);
    checkOutput("rst_ready", sample_ready, 1);
    watchIdle(200, seen);
    checkOutput("idle_rises", rises, 0);
    checkOutput("idle_active", seen, 0);

    $display("[TB] single-sample frames");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].sample);
      if (i == 0) begin
        checkOutput("latency_n", spi_active_out, 0);
        @(negedge clk_25mhz);
        checkOutput("latency_n1", spi_active_out, 1);
        checkOutput("busy_frame", busy, 1);
      end
      waitFrames(i + 1, 400);
      if (frames.size() > i) begin
        checkOutput($sformatf("frame_%0d", i), frames[i], vecs[i].frame);
        checkOutput($sformatf("active_len_%0d", i), lens[i], 129);
        checkOutput($sformatf("sclk_pulses_%0d", i), frame_rises[i], 16);
      end
    end
    repeat (10) @(negedge clk_25mhz);
    checkOutput("busy_done", busy, 0);

    $display("[TB] six back-to-back strobes");
    doReset();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_25mhz);
      sample_in = 16'(i << 4);
      sample_valid = 1'b1;
    end
    @(negedge clk_25mhz);
    sample_valid = 1'b0;
    checkOutput("burst_overflow", overflow_count, 1);
    waitFrames(5, 5 * 131 + 200);
    repeat (300) @(negedge clk_25mhz);
    checkOutput("burst_frames", frames.size(), 5);
    for (int i = 0; i < 5 && i < frames.size(); i++) begin
`ifdef DAC_SIGNED_OFFSET_EN
      checkOutput($sformatf("burst_frame_%0d", i), frames[i], 16'h3801 + 16'(i));
`else
      checkOutput($sformatf("burst_frame_%0d", i), frames[i], 16'h3001 + 16'(i));
`endif
    end

    $display("[TB] inter-frame gap");
    doReset();
    @(negedge clk_25mhz);
    sample_in = 16'hAAA0;
    sample_valid = 1'b1;
    @(negedge clk_25mhz);
    sample_in = 16'h5550;
    @(negedge clk_25mhz);
    sample_valid = 1'b0;
    waitFrames(2, 400);
    checkOutput("gap_count", gaps.size() >= 1, 1);
    if (gaps.size() >= 1) checkOutput("gap_len", gaps[0], 2);
    if (frames.size() >= 2) begin
`ifdef DAC_SIGNED_OFFSET_EN
      checkOutput("gap_frame_0", frames[0], 16'h32AA);
      checkOutput("gap_frame_1", frames[1], 16'h3D55);
`else
      checkOutput("gap_frame_0", frames[0], 16'h3AAA);
      checkOutput("gap_frame_1", frames[1], 16'h3555);
`endif
    end

    $display("[TB] reset mid-frame");
    doReset();
    applyStimulus(16'hC0DE);
    applyStimulus(16'h1230);
    c = 0;
    while (rises < 8 && c < 300) begin
      @(negedge clk_25mhz);
      c++;
    end
    checkOutput("abort_reached", rises, 8);
    reset = 1'b0;
    @(negedge clk_25mhz);
    checkOutput("abort_sclk", spi_audio_clk, 0);
    checkOutput("abort_mosi", spi_mosi_out, 0);
    checkOutput("abort_active", spi_active_out, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ready", sample_ready, 1);
    repeat (3) @(negedge clk_25mhz);
    checkOutput("abort_rises_held", rises, 8);
    reset = 1'b1;
    clearMon();
    watchIdle(300, seen);
    checkOutput("abort_no_frame", seen, 0);
    checkOutput("abort_no_sclk", rises, 0);
    checkOutput("abort_busy_after", busy, 0);

    $display("[TB] overflow saturation");
    doReset();
    @(negedge clk_25mhz);
    sample_in = 16'h1230;
    sample_valid = 1'b1;
    repeat (300) @(negedge clk_25mhz);
    sample_valid = 1'b0;
    @(negedge clk_25mhz);
    checkOutput("sat_ready", sample_ready, 0);
    checkOutput("sat_overflow", overflow_count, 255);
    sample_valid = 1'b1;
    repeat (20) @(negedge clk_25mhz);
    sample_valid = 1'b0;
    @(negedge clk_25mhz);
    checkOutput("sat_no_wrap", overflow_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_spi_serializer.md
# dac_spi_serializer

Output stage of the audio path: accepts 16-bit samples from the effect/mux stage (one-cycle valid pulse, same style as the receiver's data-ready strobe) and buffers them in a small FIFO. Each sample is converted to a 12-bit DAC code and shifted out as a 16-bit SPI mode-0 frame (4 config bits + 12 data bits) to an MCP4921-class DAC. Sits between the sample multiplexer in `top` and the board DAC pins.

## Interface

- `CLK_DIV`, 4: SCLK half-period in `clk_25mhz` cycles (≥1); SCLK = 25 MHz / (2·CLK_DIV).
- `CFG_BITS`, 4'b0011: frame bits [15:12] (A/B=0, BUF=0, GA=1, SHDN=1).
- `FIFO_DEPTH`, 4: sample FIFO entries, power of two, ≥2.
- `GAP_CYCLES`, 2: minimum `spi_active_out` low time between frames, ≥1.

- `clk_25mhz` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `sample_in` in 16: audio sample.
- `sample_valid` in 1: write strobe, sampled each rising edge.
- `sample_ready` out 1: high when a write this cycle will be accepted.
- `spi_audio_clk` out 1: DAC SCLK, idle low.
- `spi_mosi_out` out 1: DAC data, MSB first.
- `spi_active_out` out 1: high for the duration of a frame; `top` inverts it for DAC CS_n.
- `busy` out 1: high when a frame is in progress or the FIFO is non-empty.
- `overflow_count` out 8: dropped-sample counter, saturating.

## Operation

- All outputs are registered. Reset values: `spi_audio_clk`=0, `spi_mosi_out`=0, `spi_active_out`=0, `busy`=0, `overflow_count`=0, `sample_ready`=1. FIFO is empty and FSM is in IDLE.
- Write: the sample is accepted when `sample_valid` is high and the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Otherwise the sample is dropped and `overflow_count` increments, saturating at 255.
  - Simultaneous push and pop leaves the count unchanged.
- Conversion: `dac12 = sample[15:4]`, truncating the low 4 bits. Frame = {CFG_BITS, dac12}.
- FSM:
  - IDLE → LOAD when the FIFO is non-empty.
  - LOAD (1 cycle): pop the FIFO, latch the frame, `spi_active_out`←1, `spi_audio_clk`←0, `spi_mosi_out`←frame[15]. Go to SHIFT.
  - SHIFT: 16 bits, each 2·CLK_DIV cycles. SCLK is low for the first half and high for the second. MOSI updates on the SCLK falling edge to the next bit; the DAC samples on the rising edge. After the 16th high half, SCLK returns low and the FSM goes to GAP.
  - GAP: `spi_active_out`=0 for GAP_CYCLES, then IDLE.
- Reset low at any clock edge, including mid-frame, aborts immediately. Outputs take their reset values on that edge, the FIFO is flushed, and no further SCLK edges occur.

## Timing

- Latency: with the FIFO empty and FSM in IDLE, `sample_valid` sampled at edge N → pop/LOAD at edge N+1 → `spi_active_out` high after edge N+1.
- `spi_active_out` high time = 1 + 32·CLK_DIV cycles (129 at default).
- Frame pitch = 1 + 32·CLK_DIV + GAP_CYCLES cycles (131 at default, ≈190.8 kS/s max).
- `sample_ready` reflects the registered full flag for the current cycle.
- `overflow_count` updates one edge after the dropped strobe.

## Configuration

- `DAC_SIGNED_OFFSET_EN` defined: `sample_in` is two's-complement. Its MSB is inverted before truncation (offset binary), so 16'h8000→0x000, 16'h0000→0x800, 16'h7FFF→0xFFF.
- Undefined: `sample_in` is treated as unsigned and truncated directly.

## Test plan

- Reset held 5 cycles, then released → all outputs at reset values, `sample_ready`=1, no SCLK activity for 200 cycles.
- Single 16'hC0DE, macro undefined → MOSI captured on 16 SCLK rises = 16'h3C0D; `spi_active_out` high exactly 129 cycles; 16 SCLK pulses. With the macro defined → 16'h340D.
- Six `sample_valid` pulses on consecutive cycles (values 1..6 <<4), starting from IDLE → five frames carrying 0x001..0x005 in order, `overflow_count`=1, 6th sample absent.
- Two queued samples → `spi_active_out` low exactly GAP_CYCLES (2) between frames; second frame starts on the following cycle.
- Reset asserted after the 8th SCLK rise of a frame → all outputs 0 on that edge, no further SCLK edges, a queued sample is discarded, `busy`=0 after release.
- FIFO held full while 300 extra strobes arrive → `overflow_count` saturates at 255 and does not wrap.
